// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared response codes and FSM state types for the AXI4-Lite interconnect
package axil_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_t;
endpackage

// File: rtl/axil_addr_decoder.sv
// rtl/axil_addr_decoder.sv - combinational base/mask decoder, lowest matching slave wins
module axil_addr_decoder #(
    parameter int                      N_SLAVES = 2,
    parameter logic [N_SLAVES*32-1:0]  SLV_BASE = {32'h1000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0]  SLV_MASK = {32'hF000_0000, 32'hFFFF_0000}
) (
    input  logic [31:0]         i_addr,
    output logic [N_SLAVES-1:0] o_sel,
    output logic                o_hit
);
    always_comb begin
        o_sel = '0;
        o_hit = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (!o_hit && ((i_addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32])) begin
                o_sel[i] = 1'b1;
                o_hit    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axil_interconnect.sv
// rtl/axil_interconnect.sv - 1-to-N AXI4-Lite interconnect, one outstanding write and one read
module axil_interconnect
    import axil_pkg::*;
#(
    parameter int                      N_SLAVES = 2,
    parameter logic [N_SLAVES*32-1:0]  SLV_BASE = {32'h1000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0]  SLV_MASK = {32'hF000_0000, 32'hFFFF_0000}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_axi_awvalid,
    output logic                   mem_axi_awready,
    input  logic [31:0]            mem_axi_awaddr,
    input  logic [2:0]             mem_axi_awprot,
    input  logic                   mem_axi_wvalid,
    output logic                   mem_axi_wready,
    input  logic [31:0]            mem_axi_wdata,
    input  logic [3:0]             mem_axi_wstrb,
    output logic                   mem_axi_bvalid,
    input  logic                   mem_axi_bready,
    output logic [1:0]             mem_axi_bresp,
    input  logic                   mem_axi_arvalid,
    output logic                   mem_axi_arready,
    input  logic [31:0]            mem_axi_araddr,
    input  logic [2:0]             mem_axi_arprot,
    output logic                   mem_axi_rvalid,
    input  logic                   mem_axi_rready,
    output logic [31:0]            mem_axi_rdata,
    output logic [1:0]             mem_axi_rresp,
    output logic [N_SLAVES-1:0]    slv_axi_awvalid,
    input  logic [N_SLAVES-1:0]    slv_axi_awready,
    output logic [N_SLAVES*32-1:0] slv_axi_awaddr,
    output logic [N_SLAVES*3-1:0]  slv_axi_awprot,
    output logic [N_SLAVES-1:0]    slv_axi_wvalid,
    input  logic [N_SLAVES-1:0]    slv_axi_wready,
    output logic [N_SLAVES*32-1:0] slv_axi_wdata,
    output logic [N_SLAVES*4-1:0]  slv_axi_wstrb,
    input  logic [N_SLAVES-1:0]    slv_axi_bvalid,
    output logic [N_SLAVES-1:0]    slv_axi_bready,
    input  logic [N_SLAVES*2-1:0]  slv_axi_bresp,
    output logic [N_SLAVES-1:0]    slv_axi_arvalid,
    input  logic [N_SLAVES-1:0]    slv_axi_arready,
    output logic [N_SLAVES*32-1:0] slv_axi_araddr,
    output logic [N_SLAVES*3-1:0]  slv_axi_arprot,
    input  logic [N_SLAVES-1:0]    slv_axi_rvalid,
    output logic [N_SLAVES-1:0]    slv_axi_rready,
    input  logic [N_SLAVES*32-1:0] slv_axi_rdata,
    input  logic [N_SLAVES*2-1:0]  slv_axi_rresp
);
    w_state_t              r_wstate, w_wnext;
    r_state_t              r_rstate, w_rnext;
    logic                  r_awready, r_wready, r_aw_done, r_w_done, r_bvalid;
    logic [31:0]           r_awaddr, r_wdata;
    logic [2:0]            r_awprot;
    logic [3:0]            r_wstrb;
    logic [1:0]            r_bresp;
    logic [N_SLAVES-1:0]   r_wsel, r_slv_awvalid, r_slv_wvalid, r_slv_bready;
    logic                  r_arready, r_rvalid;
    logic [31:0]           r_araddr, r_rdata;
    logic [2:0]            r_arprot;
    logic [1:0]            r_rresp;
    logic [N_SLAVES-1:0]   r_rsel, r_slv_arvalid, r_slv_rready;

    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_aw_have, w_w_have;
    logic [31:0]           w_waddr;
    logic [N_SLAVES-1:0]   w_wdec_sel, w_rdec_sel;
    logic                  w_wdec_hit, w_rdec_hit;
    logic [1:0]            w_sbresp, w_srresp;
    logic [31:0]           w_srdata;

    assign w_aw_hs   = mem_axi_awvalid & r_awready;
    assign w_w_hs    = mem_axi_wvalid & r_wready;
    assign w_ar_hs   = mem_axi_arvalid & r_arready;
    assign w_aw_have = r_aw_done | w_aw_hs;
    assign w_w_have  = r_w_done | w_w_hs;
    // Decode the live address in the capture cycle so the slave valid can rise on the next edge.
    assign w_waddr   = r_aw_done ? r_awaddr : mem_axi_awaddr;

    axil_addr_decoder #(.N_SLAVES(N_SLAVES), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)) u_wdec (
        .i_addr(w_waddr), .o_sel(w_wdec_sel), .o_hit(w_wdec_hit)
    );
    axil_addr_decoder #(.N_SLAVES(N_SLAVES), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)) u_rdec (
        .i_addr(mem_axi_araddr), .o_sel(w_rdec_sel), .o_hit(w_rdec_hit)
    );

    always_comb begin
        w_sbresp = '0;
        w_srresp = '0;
        w_srdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (r_wsel[i]) w_sbresp = slv_axi_bresp[i*2 +: 2];
            if (r_rsel[i]) begin
                w_srresp = slv_axi_rresp[i*2 +: 2];
                w_srdata = slv_axi_rdata[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wnext;
            r_rstate <= w_rnext;
        end
    end

    always_comb begin
        w_wnext = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_have && w_w_have) w_wnext = w_wdec_hit ? W_ISSUE : W_RESP;
            W_ISSUE: if (!(|(r_slv_awvalid & ~slv_axi_awready)) &&
                         !(|(r_slv_wvalid & ~slv_axi_wready))) w_wnext = W_WAIT;
            W_WAIT:  if (|(r_slv_bready & slv_axi_bvalid)) w_wnext = W_RESP;
            W_RESP:  if (mem_axi_bready) w_wnext = W_IDLE;
            default: w_wnext = W_IDLE;
        endcase
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rnext = w_rdec_hit ? R_ISSUE : R_RESP;
            R_ISSUE: if (!(|(r_slv_arvalid & ~slv_axi_arready))) w_rnext = R_WAIT;
            R_WAIT:  if (|(r_slv_rready & slv_axi_rvalid)) w_rnext = R_RESP;
            R_RESP:  if (mem_axi_rready) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_awready <= 1'b0; r_wready <= 1'b0; r_aw_done <= 1'b0; r_w_done <= 1'b0;
            r_awaddr <= '0; r_awprot <= '0; r_wdata <= '0; r_wstrb <= '0;
            r_wsel <= '0; r_slv_awvalid <= '0; r_slv_wvalid <= '0; r_slv_bready <= '0;
            r_bvalid <= 1'b0; r_bresp <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_awaddr <= mem_axi_awaddr;
                r_awprot <= mem_axi_awprot;
            end
            if (w_w_hs) begin
                r_wdata <= mem_axi_wdata;
                r_wstrb <= mem_axi_wstrb;
            end
            case (r_wstate)
                W_IDLE: begin
                    r_aw_done <= w_aw_have;
                    r_w_done  <= w_w_have;
                    r_awready <= !w_aw_have;
                    r_wready  <= !w_w_have;
                    if (w_wnext != W_IDLE) begin
                        r_aw_done     <= 1'b0;
                        r_w_done      <= 1'b0;
                        r_wsel        <= w_wdec_sel;
                        r_slv_awvalid <= w_wdec_sel;
                        r_slv_wvalid  <= w_wdec_sel;
                        r_bvalid      <= !w_wdec_hit;
                        r_bresp       <= w_wdec_hit ? RESP_OKAY : RESP_DECERR;
                    end
                end
                W_ISSUE: begin
                    r_slv_awvalid <= r_slv_awvalid & ~slv_axi_awready;
                    r_slv_wvalid  <= r_slv_wvalid & ~slv_axi_wready;
                    if (w_wnext == W_WAIT) r_slv_bready <= r_wsel;
                end
                W_WAIT: if (w_wnext == W_RESP) begin
                    r_slv_bready <= '0;
                    r_bvalid     <= 1'b1;
                    r_bresp      <= w_sbresp;
                end
                W_RESP: if (w_wnext == W_IDLE) begin
                    r_bvalid  <= 1'b0;
                    r_awready <= 1'b1;
                    r_wready  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_arready <= 1'b0; r_araddr <= '0; r_arprot <= '0; r_rsel <= '0;
            r_slv_arvalid <= '0; r_slv_rready <= '0;
            r_rvalid <= 1'b0; r_rdata <= '0; r_rresp <= RESP_OKAY;
        end else begin
            r_arready <= (w_rnext == R_IDLE);
            case (r_rstate)
                R_IDLE: if (w_ar_hs) begin
                    r_araddr      <= mem_axi_araddr;
                    r_arprot      <= mem_axi_arprot;
                    r_rsel        <= w_rdec_sel;
                    r_slv_arvalid <= w_rdec_sel;
                    if (!w_rdec_hit) begin
                        r_rvalid <= 1'b1;
                        r_rdata  <= '0;
                        r_rresp  <= RESP_DECERR;
                    end
                end
                R_ISSUE: begin
                    r_slv_arvalid <= r_slv_arvalid & ~slv_axi_arready;
                    if (w_rnext == R_WAIT) r_slv_rready <= r_rsel;
                end
                R_WAIT: if (w_rnext == R_RESP) begin
                    r_slv_rready <= '0;
                    r_rvalid     <= 1'b1;
                    r_rdata      <= w_srdata;
                    r_rresp      <= w_srresp;
                end
                R_RESP: if (w_rnext == R_IDLE) r_rvalid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign mem_axi_awready = r_awready;
    assign mem_axi_wready  = r_wready;
    assign mem_axi_bvalid  = r_bvalid;
    assign mem_axi_bresp   = r_bresp;
    assign mem_axi_arready = r_arready;
    assign mem_axi_rvalid  = r_rvalid;
    assign mem_axi_rdata   = r_rdata;
    assign mem_axi_rresp   = r_rresp;
    // Payload is broadcast; only the selected slave ever sees a valid.
    assign slv_axi_awvalid = r_slv_awvalid;
    assign slv_axi_awaddr  = {N_SLAVES{r_awaddr}};
    assign slv_axi_awprot  = {N_SLAVES{r_awprot}};
    assign slv_axi_wvalid  = r_slv_wvalid;
    assign slv_axi_wdata   = {N_SLAVES{r_wdata}};
    assign slv_axi_wstrb   = {N_SLAVES{r_wstrb}};
    assign slv_axi_bready  = r_slv_bready;
    assign slv_axi_arvalid = r_slv_arvalid;
    assign slv_axi_araddr  = {N_SLAVES{r_araddr}};
    assign slv_axi_arprot  = {N_SLAVES{r_arprot}};
    assign slv_axi_rready  = r_slv_rready;
endmodule

// File: tb/tb_axil_interconnect.sv
// tb/tb_axil_interconnect.sv - directed self-checking bench for axil_interconnect
module tb_axil_interconnect;
    import axil_pkg::*;
    localparam int N = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic mem_awvalid = 0, mem_wvalid = 0, mem_bready = 1, mem_arvalid = 0, mem_rready = 1;
    logic [31:0] mem_awaddr = 0, mem_wdata = 0, mem_araddr = 0;
    logic [2:0] mem_awprot = 0, mem_arprot = 0;
    logic [3:0] mem_wstrb = 0;
    logic mem_awready, mem_wready, mem_bvalid, mem_arready, mem_rvalid;
    logic [1:0] mem_bresp, mem_rresp;
    logic [31:0] mem_rdata;

    logic [N-1:0] slv_awvalid, slv_wvalid, slv_bready, slv_arvalid, slv_rready;
    logic [N-1:0] s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [N*32-1:0] slv_awaddr, slv_wdata, slv_araddr, s_rdata;
    logic [N*3-1:0] slv_awprot, slv_arprot;
    logic [N*4-1:0] slv_wstrb;
    logic [N*2-1:0] s_bresp, s_rresp;

    int n_tests = 0;
    int n_fail = 0;

    axil_interconnect dut (
        .clk(clk), .reset(reset),
        .mem_axi_awvalid(mem_awvalid), .mem_axi_awready(mem_awready), .mem_axi_awaddr(mem_awaddr),
        .mem_axi_awprot(mem_awprot), .mem_axi_wvalid(mem_wvalid), .mem_axi_wready(mem_wready),
        .mem_axi_wdata(mem_wdata), .mem_axi_wstrb(mem_wstrb), .mem_axi_bvalid(mem_bvalid),
        .mem_axi_bready(mem_bready), .mem_axi_bresp(mem_bresp), .mem_axi_arvalid(mem_arvalid),
        .mem_axi_arready(mem_arready), .mem_axi_araddr(mem_araddr), .mem_axi_arprot(mem_arprot),
        .mem_axi_rvalid(mem_rvalid), .mem_axi_rready(mem_rready), .mem_axi_rdata(mem_rdata),
        .mem_axi_rresp(mem_rresp),
        .slv_axi_awvalid(slv_awvalid), .slv_axi_awready(s_awready), .slv_axi_awaddr(slv_awaddr),
        .slv_axi_awprot(slv_awprot), .slv_axi_wvalid(slv_wvalid), .slv_axi_wready(s_wready),
        .slv_axi_wdata(slv_wdata), .slv_axi_wstrb(slv_wstrb), .slv_axi_bvalid(s_bvalid),
        .slv_axi_bready(slv_bready), .slv_axi_bresp(s_bresp), .slv_axi_arvalid(slv_arvalid),
        .slv_axi_arready(s_arready), .slv_axi_araddr(slv_araddr), .slv_axi_arprot(slv_arprot),
        .slv_axi_rvalid(s_rvalid), .slv_axi_rready(slv_rready), .slv_axi_rdata(s_rdata),
        .slv_axi_rresp(s_rresp)
    );

    // Slave models: always-ready address/data, response after a configurable wait.
    int          b_wait [N];
    int          r_wait [N];
    logic [1:0]  b_resp_cfg [N];
    logic [1:0]  r_resp_cfg [N];
    logic [31:0] r_data_cfg [N];
    logic [N-1:0] m_got_aw, m_got_w, m_b_busy, m_r_busy;
    int m_b_cnt [N];
    int m_r_cnt [N];
    int aw_cnt [N];
    int w_cnt [N];
    int ar_cnt [N];
    int s0_vld_cnt;

    assign s_awready = '1;
    assign s_wready  = '1;
    assign s_arready = '1;

    always_comb begin
        s_bvalid = '0; s_rvalid = '0; s_bresp = '0; s_rresp = '0; s_rdata = '0;
        for (int i = 0; i < N; i++) begin
            s_bvalid[i] = m_b_busy[i] && (m_b_cnt[i] == 0);
            s_rvalid[i] = m_r_busy[i] && (m_r_cnt[i] == 0);
            s_bresp[i*2 +: 2]  = b_resp_cfg[i];
            s_rresp[i*2 +: 2]  = r_resp_cfg[i];
            s_rdata[i*32 +: 32] = r_data_cfg[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_got_aw[i] <= 1'b0; m_got_w[i] <= 1'b0; m_b_busy[i] <= 1'b0; m_r_busy[i] <= 1'b0;
                m_b_cnt[i] <= 0; m_r_cnt[i] <= 0; aw_cnt[i] <= 0; w_cnt[i] <= 0; ar_cnt[i] <= 0;
            end else begin
                if (slv_awvalid[i] && s_awready[i]) begin
                    m_got_aw[i] <= 1'b1;
                    aw_cnt[i]   <= aw_cnt[i] + 1;
                end
                if (slv_wvalid[i] && s_wready[i]) begin
                    m_got_w[i] <= 1'b1;
                    w_cnt[i]   <= w_cnt[i] + 1;
                end
                if (!m_b_busy[i] && (m_got_aw[i] || (slv_awvalid[i] && s_awready[i]))
                                 && (m_got_w[i] || (slv_wvalid[i] && s_wready[i]))) begin
                    m_b_busy[i] <= 1'b1;
                    m_b_cnt[i]  <= b_wait[i];
                    m_got_aw[i] <= 1'b0;
                    m_got_w[i]  <= 1'b0;
                end else if (m_b_busy[i]) begin
                    if (m_b_cnt[i] != 0) m_b_cnt[i] <= m_b_cnt[i] - 1;
                    else if (slv_bready[i]) m_b_busy[i] <= 1'b0;
                end
                if (!m_r_busy[i] && slv_arvalid[i] && s_arready[i]) begin
                    m_r_busy[i] <= 1'b1;
                    m_r_cnt[i]  <= r_wait[i];
                    ar_cnt[i]   <= ar_cnt[i] + 1;
                end else if (m_r_busy[i]) begin
                    if (m_r_cnt[i] != 0) m_r_cnt[i] <= m_r_cnt[i] - 1;
                    else if (slv_rready[i]) m_r_busy[i] <= 1'b0;
                end
            end
        end
        if (reset) s0_vld_cnt <= 0;
        else if (slv_awvalid[0] || slv_wvalid[0] || slv_arvalid[0]) s0_vld_cnt <= s0_vld_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({mem_awready, mem_wready, mem_arready, mem_bvalid, mem_rvalid} !== 5'b0) begin
            n_fail++; $display("FAIL reset_up_vr: got %b expected 00000", {mem_awready, mem_wready, mem_arready, mem_bvalid, mem_rvalid});
        end
        n_tests++;
        if ({slv_awvalid, slv_wvalid, slv_arvalid, slv_bready, slv_rready} !== 10'b0) begin
            n_fail++; $display("FAIL reset_slv_vr: got %b expected 0", {slv_awvalid, slv_wvalid, slv_arvalid, slv_bready, slv_rready});
        end
        n_tests++;
        if ({mem_bresp, mem_rresp, mem_rdata} !== 36'h0) begin
            n_fail++; $display("FAIL reset_resp: got %h expected 0", {mem_bresp, mem_rresp, mem_rdata});
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if ({mem_awready, mem_wready, mem_arready} !== 3'b111) begin
            n_fail++; $display("FAIL reset_release_ready: got %b expected 111", {mem_awready, mem_wready, mem_arready});
        end
    endtask

    task automatic test_write_basic();
        int a0, a1;
        a0 = aw_cnt[0]; a1 = aw_cnt[1];
        mem_awvalid = 1; mem_awaddr = 32'h0000_0010; mem_awprot = 3'b010;
        mem_wvalid = 1; mem_wdata = 32'hCAFE_F00D; mem_wstrb = 4'hF;
        tick();
        mem_awvalid = 0; mem_wvalid = 0;
        n_tests++;
        if ({slv_awvalid, slv_wvalid, mem_bvalid} !== 5'b01010) begin
            n_fail++; $display("FAIL wr_issue_valids: got %b expected 01010", {slv_awvalid, slv_wvalid, mem_bvalid});
        end
        n_tests++;
        if ({slv_awaddr[31:0], slv_awprot[2:0], slv_wdata[31:0], slv_wstrb[3:0]} !== {32'h10, 3'b010, 32'hCAFE_F00D, 4'hF}) begin
            n_fail++; $display("FAIL wr_payload: got %h expected %h", {slv_awaddr[31:0], slv_awprot[2:0], slv_wdata[31:0], slv_wstrb[3:0]}, {32'h10, 3'b010, 32'hCAFE_F00D, 4'hF});
        end
        tick();
        n_tests++;
        if ({slv_awvalid, slv_wvalid, slv_bready, mem_bvalid} !== 7'b0000010) begin
            n_fail++; $display("FAIL wr_wait: got %b expected 0000010", {slv_awvalid, slv_wvalid, slv_bready, mem_bvalid});
        end
        tick();
        n_tests++;
        if ({mem_bvalid, mem_bresp} !== 3'b100) begin
            n_fail++; $display("FAIL wr_bresp_t3: got %b expected 100", {mem_bvalid, mem_bresp});
        end
        tick();
        n_tests++;
        if ({mem_bvalid, mem_awready, mem_wready} !== 3'b011) begin
            n_fail++; $display("FAIL wr_back_idle: got %b expected 011", {mem_bvalid, mem_awready, mem_wready});
        end
        n_tests++;
        if ((aw_cnt[0] - a0 != 1) || (aw_cnt[1] - a1 != 0)) begin
            n_fail++; $display("FAIL wr_aw_count: got %0d/%0d expected 1/0", aw_cnt[0] - a0, aw_cnt[1] - a1);
        end
    endtask

    task automatic test_read_wait();
        int v0, k;
        v0 = s0_vld_cnt;
        r_wait[1] = 5; r_data_cfg[1] = 32'h1234_5678; r_resp_cfg[1] = RESP_OKAY;
        mem_arvalid = 1; mem_araddr = 32'h1000_0004; mem_arprot = 3'b001;
        tick();
        mem_arvalid = 0;
        n_tests++;
        if ({slv_arvalid, slv_araddr[63:32], slv_arprot[5:3], mem_arready} !== {2'b10, 32'h1000_0004, 3'b001, 1'b0}) begin
            n_fail++; $display("FAIL rd_issue: got %h expected %h", {slv_arvalid, slv_araddr[63:32], slv_arprot[5:3], mem_arready}, {2'b10, 32'h1000_0004, 3'b001, 1'b0});
        end
        k = 0;
        while (!mem_rvalid && k < 20) begin tick(); k++; end
        n_tests++;
        if (k != 7) begin
            n_fail++; $display("FAIL rd_latency: got %0d cycles expected 7", k);
        end
        n_tests++;
        if ({mem_rdata, mem_rresp} !== {32'h1234_5678, 2'b00}) begin
            n_fail++; $display("FAIL rd_data: got %h expected %h", {mem_rdata, mem_rresp}, {32'h1234_5678, 2'b00});
        end
        tick();
        n_tests++;
        if ({mem_rvalid, mem_arready} !== 2'b01) begin
            n_fail++; $display("FAIL rd_back_idle: got %b expected 01", {mem_rvalid, mem_arready});
        end
        n_tests++;
        if (s0_vld_cnt - v0 != 0) begin
            n_fail++; $display("FAIL rd_slave0_quiet: got %0d expected 0", s0_vld_cnt - v0);
        end
        r_wait[1] = 0;
    endtask

    task automatic test_decode_miss();
        mem_arvalid = 1; mem_araddr = 32'h2000_0000;
        tick();
        mem_arvalid = 0;
        n_tests++;
        if ({mem_rvalid, mem_rresp, mem_rdata, slv_arvalid} !== {1'b1, 2'b11, 32'h0, 2'b00}) begin
            n_fail++; $display("FAIL miss_read: got %h expected %h", {mem_rvalid, mem_rresp, mem_rdata, slv_arvalid}, {1'b1, 2'b11, 32'h0, 2'b00});
        end
        tick();
        mem_awvalid = 1; mem_awaddr = 32'h2000_0000; mem_wvalid = 1; mem_wdata = 32'hDEAD_BEEF;
        tick();
        mem_awvalid = 0; mem_wvalid = 0;
        n_tests++;
        if ({mem_bvalid, mem_bresp, slv_awvalid, slv_wvalid} !== 7'b1110000) begin
            n_fail++; $display("FAIL miss_write: got %b expected 1110000", {mem_bvalid, mem_bresp, slv_awvalid, slv_wvalid});
        end
        tick();
        n_tests++;
        if ({mem_bvalid, mem_awready, mem_wready, mem_rvalid} !== 4'b0110) begin
            n_fail++; $display("FAIL miss_done: got %b expected 0110", {mem_bvalid, mem_awready, mem_wready, mem_rvalid});
        end
    endtask

    task automatic test_decode_bounds();
        logic [31:0] addrs [4] = '{32'h0000_FFFC, 32'h0001_0000, 32'h1FFF_FFFC, 32'h0FFF_0000};
        logic [1:0]  exps  [4] = '{2'b01, 2'b00, 2'b10, 2'b00};
        int k;
        for (int j = 0; j < 4; j++) begin
            mem_arvalid = 1; mem_araddr = addrs[j];
            tick();
            mem_arvalid = 0;
            n_tests++;
            if (slv_arvalid !== exps[j]) begin
                n_fail++; $display("FAIL decode_sel[%0d]: got %b expected %b", j, slv_arvalid, exps[j]);
            end
            k = 0;
            while (!mem_rvalid && k < 10) begin tick(); k++; end
            n_tests++;
            if (mem_rresp !== ((exps[j] == 2'b00) ? 2'b11 : 2'b00) || !mem_rvalid) begin
                n_fail++; $display("FAIL decode_resp[%0d]: got rvalid %b rresp %b expected rvalid 1 rresp %b", j, mem_rvalid, mem_rresp, (exps[j] == 2'b00) ? 2'b11 : 2'b00);
            end
            tick();
        end
    endtask

    task automatic test_w_before_aw();
        int a0, w0, k;
        a0 = aw_cnt[0]; w0 = w_cnt[0];
        mem_wvalid = 1; mem_wdata = 32'h0BAD_F00D; mem_wstrb = 4'h3;
        tick();
        mem_wvalid = 0;
        for (int j = 0; j < 3; j++) begin
            n_tests++;
            if ({mem_wready, mem_awready, slv_wvalid} !== 4'b0100) begin
                n_fail++; $display("FAIL wfirst_ready[%0d]: got %b expected 0100", j, {mem_wready, mem_awready, slv_wvalid});
            end
            if (j < 2) tick();
        end
        mem_awvalid = 1; mem_awaddr = 32'h0000_0024;
        tick();
        mem_awvalid = 0;
        n_tests++;
        if ({slv_awvalid, slv_wvalid, slv_awaddr[31:0], slv_wdata[31:0], slv_wstrb[3:0]} !== {4'b0101, 32'h24, 32'h0BAD_F00D, 4'h3}) begin
            n_fail++; $display("FAIL wfirst_issue: got %h expected %h", {slv_awvalid, slv_wvalid, slv_awaddr[31:0], slv_wdata[31:0], slv_wstrb[3:0]}, {4'b0101, 32'h24, 32'h0BAD_F00D, 4'h3});
        end
        k = 0;
        while (!mem_bvalid && k < 10) begin tick(); k++; end
        tick();
        n_tests++;
        if ({mem_bvalid, k[3:0]} !== {1'b0, 4'd2}) begin
            n_fail++; $display("FAIL wfirst_bvalid_once: got bvalid %b after %0d cycles expected 0 after 2", mem_bvalid, k);
        end
        n_tests++;
        if ((aw_cnt[0] - a0 != 1) || (w_cnt[0] - w0 != 1)) begin
            n_fail++; $display("FAIL wfirst_pair_count: got %0d/%0d expected 1/1", aw_cnt[0] - a0, w_cnt[0] - w0);
        end
    endtask

    task automatic test_concurrent();
        b_resp_cfg[0] = RESP_SLVERR; r_data_cfg[1] = 32'hA5A5_0001;
        mem_bready = 0;
        mem_awvalid = 1; mem_awaddr = 32'h0000_0100; mem_wvalid = 1; mem_wdata = 32'h11;
        mem_arvalid = 1; mem_araddr = 32'h1000_0008;
        tick();
        mem_awvalid = 0; mem_wvalid = 0; mem_arvalid = 0;
        n_tests++;
        if ({slv_awvalid, slv_arvalid} !== 4'b0110) begin
            n_fail++; $display("FAIL conc_issue: got %b expected 0110", {slv_awvalid, slv_arvalid});
        end
        tick(); tick();
        n_tests++;
        if ({mem_rvalid, mem_rdata, mem_rresp} !== {1'b1, 32'hA5A5_0001, 2'b00}) begin
            n_fail++; $display("FAIL conc_read: got %h expected %h", {mem_rvalid, mem_rdata, mem_rresp}, {1'b1, 32'hA5A5_0001, 2'b00});
        end
        for (int j = 0; j < 5; j++) begin
            n_tests++;
            if ({mem_bvalid, mem_bresp} !== 3'b110) begin
                n_fail++; $display("FAIL conc_bhold[%0d]: got %b expected 110", j, {mem_bvalid, mem_bresp});
            end
            if (j == 1) begin
                n_tests++;
                if ({mem_rvalid, mem_arready} !== 2'b01) begin
                    n_fail++; $display("FAIL conc_read_done: got %b expected 01", {mem_rvalid, mem_arready});
                end
            end
            if (j == 4) mem_bready = 1;
            tick();
        end
        n_tests++;
        if ({mem_bvalid, mem_awready} !== 2'b01) begin
            n_fail++; $display("FAIL conc_write_done: got %b expected 01", {mem_bvalid, mem_awready});
        end
        b_resp_cfg[0] = RESP_OKAY;
    endtask

    task automatic test_reset_mid();
        b_wait[0] = 10;
        mem_awvalid = 1; mem_awaddr = 32'h0000_0008; mem_wvalid = 1; mem_wdata = 32'h55;
        tick();
        mem_awvalid = 0; mem_wvalid = 0;
        tick();
        n_tests++;
        if (slv_bready !== 2'b01) begin
            n_fail++; $display("FAIL mid_in_wait: got %b expected 01", slv_bready);
        end
        reset = 1;
        tick();
        n_tests++;
        if ({slv_awvalid, slv_wvalid, slv_arvalid, slv_bready, slv_rready, mem_bvalid, mem_rvalid,
             mem_awready, mem_wready, mem_arready} !== 15'b0) begin
            n_fail++; $display("FAIL mid_reset_clear: got %b expected 0", {slv_awvalid, slv_wvalid, slv_arvalid, slv_bready, slv_rready, mem_bvalid, mem_rvalid, mem_awready, mem_wready, mem_arready});
        end
        reset = 0; b_wait[0] = 0;
        tick();
        n_tests++;
        if ({mem_awready, mem_wready, mem_arready} !== 3'b111) begin
            n_fail++; $display("FAIL mid_release_ready: got %b expected 111", {mem_awready, mem_wready, mem_arready});
        end
        mem_awvalid = 1; mem_awaddr = 32'h0000_0004; mem_wvalid = 1; mem_wdata = 32'h77;
        tick();
        mem_awvalid = 0; mem_wvalid = 0;
        n_tests++;
        if ({slv_awvalid, slv_wdata[31:0]} !== {2'b01, 32'h77}) begin
            n_fail++; $display("FAIL mid_after_issue: got %h expected %h", {slv_awvalid, slv_wdata[31:0]}, {2'b01, 32'h77});
        end
        tick(); tick();
        n_tests++;
        if ({mem_bvalid, mem_bresp} !== 3'b100) begin
            n_fail++; $display("FAIL mid_after_resp: got %b expected 100", {mem_bvalid, mem_bresp});
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            b_wait[i] = 0; r_wait[i] = 0;
            b_resp_cfg[i] = RESP_OKAY; r_resp_cfg[i] = RESP_OKAY; r_data_cfg[i] = 32'h0;
        end
        test_reset();
        test_write_basic();
        test_read_wait();
        test_decode_miss();
        test_decode_bounds();
        test_w_before_aw();
        test_concurrent();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
